// File: rtl/quad_decoder_counter_if.sv
// Host-side bus of quad_decoder_counter: encoder pins, load/clear controls and position/status outputs.
// Carries the index pin z only when QDEC_INDEX_EN is defined.
interface quad_decoder_counter_if #(
    parameter int N = 16
);
    logic         a;
    logic         b;
`ifdef QDEC_INDEX_EN
    logic         z;
`endif
    logic         syn_clr;
    logic         load;
    logic [N-1:0] d;
    logic [N-1:0] q;
    logic         dir;
    logic         step_tick;
    logic         err_tick;
    logic [7:0]   err_cnt;
    logic         max_tick;
    logic         min_tick;

`ifdef QDEC_INDEX_EN
    modport master (
        output a, b, z, syn_clr, load, d,
        input  q, dir, step_tick, err_tick, err_cnt, max_tick, min_tick
    );

    modport slave (
        input  a, b, z, syn_clr, load, d,
        output q, dir, step_tick, err_tick, err_cnt, max_tick, min_tick
    );
`else
    modport master (
        output a, b, syn_clr, load, d,
        input  q, dir, step_tick, err_tick, err_cnt, max_tick, min_tick
    );

    modport slave (
        input  a, b, syn_clr, load, d,
        output q, dir, step_tick, err_tick, err_cnt, max_tick, min_tick
    );
`endif
endinterface

// File: rtl/quad_decoder_counter.sv
// Quadrature decoder feeding an N-bit modulo up/down position counter with load/clear and error counting.
// Optional index-pulse clear of the position is enabled by defining QDEC_INDEX_EN.
module quad_decoder_counter #(
    parameter int N           = 16,
    parameter int SYNC_STAGES = 2   // legal range 2..4
) (
    input  logic                 clk,
    input  logic                 reset,
    quad_decoder_counter_if.slave bus
);

    typedef enum logic [1:0] {
        STEP_NONE,
        STEP_FWD,
        STEP_REV,
        STEP_ERR
    } step_e;

    localparam int               ARM_W    = $clog2(SYNC_STAGES + 2);
    localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0] a_sync_q, a_sync_d;
    logic [SYNC_STAGES-1:0] b_sync_q, b_sync_d;
    logic [1:0]             s;
    logic [1:0]             p_q, p_d;
    logic [ARM_W-1:0]       arm_cnt_q, arm_cnt_d;
    logic                   armed;
    logic [N-1:0]           pos_q, pos_d;
    logic                   dir_q, dir_d;
    logic                   step_tick_q, step_tick_d;
    logic                   err_tick_q, err_tick_d;
    logic [7:0]             err_cnt_q, err_cnt_d;
    logic                   index_hit;
    step_e                  step;

`ifdef QDEC_INDEX_EN
    logic [SYNC_STAGES-1:0] z_sync_q, z_sync_d;
    logic                   z_prev_q, z_prev_d;
    logic                   z_s;

    assign z_s       = z_sync_q[SYNC_STAGES-1];
    assign index_hit = armed && z_s && !z_prev_q;
`else
    assign index_hit = 1'b0;
`endif

    assign s     = {a_sync_q[SYNC_STAGES-1], b_sync_q[SYNC_STAGES-1]};
    assign armed = (arm_cnt_q == ARM_DONE);

    // Gray-code transition decode of previous vs current sampled pin state.
    always_comb begin
        step = STEP_NONE;
        case ({p_q, s})
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: step = STEP_FWD;
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: step = STEP_REV;
            4'b00_11, 4'b11_00, 4'b10_01, 4'b01_10: step = STEP_ERR;
            default:                                step = STEP_NONE;
        endcase
        if (!armed) begin
            step = STEP_NONE;
        end
    end

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no latch can be inferred.
        a_sync_d    = {a_sync_q[SYNC_STAGES-2:0], bus.a};
        b_sync_d    = {b_sync_q[SYNC_STAGES-2:0], bus.b};
        p_d         = s;
        arm_cnt_d   = armed ? arm_cnt_q : arm_cnt_q + ARM_W'(1);
        step_tick_d = (step == STEP_FWD) || (step == STEP_REV);
        err_tick_d  = (step == STEP_ERR);
        dir_d       = dir_q;
        err_cnt_d   = err_cnt_q;
        pos_d       = pos_q;

        if (step_tick_d) begin
            dir_d = (step == STEP_FWD);
        end

        if (err_tick_d && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end

        // Clear/load/index win over a coincident step; the step still shows on step_tick and dir.
        if (bus.syn_clr) begin
            pos_d = '0;
        end else if (bus.load) begin
            pos_d = bus.d;
        end else if (index_hit) begin
            pos_d = '0;
        end else if (step == STEP_FWD) begin
            pos_d = pos_q + N'(1);
        end else if (step == STEP_REV) begin
            pos_d = pos_q - N'(1);
        end
    end

`ifdef QDEC_INDEX_EN
    always_comb begin
        z_sync_d = {z_sync_q[SYNC_STAGES-2:0], bus.z};
        z_prev_d = z_s;
    end
`endif

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_sync_q    <= '0;
            b_sync_q    <= '0;
            p_q         <= '0;
            arm_cnt_q   <= '0;
            pos_q       <= '0;
            dir_q       <= 1'b0;
            step_tick_q <= 1'b0;
            err_tick_q  <= 1'b0;
            err_cnt_q   <= '0;
`ifdef QDEC_INDEX_EN
            z_sync_q    <= '0;
            z_prev_q    <= 1'b0;
`endif
        end else begin
            a_sync_q    <= a_sync_d;
            b_sync_q    <= b_sync_d;
            p_q         <= p_d;
            arm_cnt_q   <= arm_cnt_d;
            pos_q       <= pos_d;
            dir_q       <= dir_d;
            step_tick_q <= step_tick_d;
            err_tick_q  <= err_tick_d;
            err_cnt_q   <= err_cnt_d;
`ifdef QDEC_INDEX_EN
            z_sync_q    <= z_sync_d;
            z_prev_q    <= z_prev_d;
`endif
        end
    end

    assign bus.q         = pos_q;
    assign bus.dir       = dir_q;
    assign bus.step_tick = step_tick_q;
    assign bus.err_tick  = err_tick_q;
    assign bus.err_cnt   = err_cnt_q;
    assign bus.max_tick  = &pos_q;
    assign bus.min_tick  = ~|pos_q;

endmodule

// File: tb/tb_quad_decoder_counter.sv
// Self-checking bench for quad_decoder_counter: vector table, latency/corner sequences and a
// randomized run against a Gray-index position model. Index tests build only with QDEC_INDEX_EN.
module tb_quad_decoder_counter;

    localparam int N   = 16;
    localparam int SS  = 2;
    localparam int LAT = SS + 1;

    typedef struct {
        logic [1:0]   ab;
        logic         clr;
        logic         ld;
        logic [N-1:0] d;
        logic [N-1:0] exp_q;
        logic         exp_dir;
        logic         exp_max;
        logic         exp_min;
    } vec_t;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    int   step_pulses;
    int   err_pulses;

    logic [1:0] gray_lut [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

    quad_decoder_counter_if #(.N(N)) bus ();

    quad_decoder_counter #(
        .N          (N),
        .SYNC_STAGES(SS)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.step_tick) step_pulses <= step_pulses + 1;
        if (bus.err_tick)  err_pulses  <= err_pulses + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_idx(input int idx);
        bus.a = gray_lut[idx][1];
        bus.b = gray_lut[idx][0];
    endtask

    task automatic do_reset(input int idx);
        reset = 1'b1;
        set_idx(idx);
        tick(3);
        reset = 1'b0;
        tick(LAT + 2);
    endtask

    vec_t vecs [9];
    int   cur_idx;
    int   base_steps;
    int   base_errs;
    logic [N-1:0] m_q;
    logic         m_dir;
    int           m_err;
    int           m_steps;

    initial begin
        checks      = 0;
        failures    = 0;
        step_pulses = 0;
        err_pulses  = 0;
        reset       = 1'b1;
        bus.a       = 1'b1;
        bus.b       = 1'b1;
        bus.syn_clr = 1'b0;
        bus.load    = 1'b0;
        bus.d       = '0;
`ifdef QDEC_INDEX_EN
        bus.z       = 1'b0;
`endif

        vecs[0] = '{2'b00, 1'b0, 1'b1, 16'hFFFE, 16'hFFFE, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{2'b10, 1'b0, 1'b0, 16'h0000, 16'hFFFF, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{2'b11, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{2'b01, 1'b0, 1'b0, 16'h0000, 16'h0001, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{2'b11, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{2'b10, 1'b0, 1'b0, 16'h0000, 16'hFFFF, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{2'b10, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{2'b10, 1'b0, 1'b1, 16'h1234, 16'h1234, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{2'b00, 1'b0, 1'b0, 16'h0000, 16'h1233, 1'b0, 1'b0, 1'b0};

        // Reset with pins at 11: outputs idle during reset, no spurious error after release.
        tick(3);
        check("rst_q", bus.q, 0);
        check("rst_min", bus.min_tick, 1);
        check("rst_max", bus.max_tick, 0);
        check("rst_step", bus.step_tick, 0);
        check("rst_err", bus.err_tick, 0);
        check("rst_dir", bus.dir, 0);
        check("rst_errcnt", bus.err_cnt, 0);
        base_errs = err_pulses;
        reset = 1'b0;
        tick(10);
        check("arm_q", bus.q, 0);
        check("arm_errcnt", bus.err_cnt, 0);
        check("arm_errpulses", err_pulses - base_errs, 0);
        check("arm_min", bus.min_tick, 1);

        // Eight forward steps with exact latency per step.
        do_reset(0);
        cur_idx    = 0;
        base_steps = step_pulses;
        for (int i = 0; i < 8; i++) begin
            cur_idx = (cur_idx + 1) % 4;
            set_idx(cur_idx);
            tick(LAT - 1);
            check($sformatf("fwd%0d_q_early", i), bus.q, i);
            check($sformatf("fwd%0d_tick_early", i), bus.step_tick, 0);
            tick(1);
            check($sformatf("fwd%0d_q", i), bus.q, i + 1);
            check($sformatf("fwd%0d_tick", i), bus.step_tick, 1);
            tick(1);
            check($sformatf("fwd%0d_tick_off", i), bus.step_tick, 0);
            tick(8 - LAT - 1);
        end
        check("fwd_q_final", bus.q, 8);
        check("fwd_dir", bus.dir, 1);
        check("fwd_pulses", step_pulses - base_steps, 8);

        // Vector table: load near max, wrap forward and back, clear, load, reverse.
        for (int i = 0; i < 9; i++) begin
            bus.a       = vecs[i].ab[1];
            bus.b       = vecs[i].ab[0];
            bus.syn_clr = vecs[i].clr;
            bus.load    = vecs[i].ld;
            bus.d       = vecs[i].d;
            tick(1);
            bus.syn_clr = 1'b0;
            bus.load    = 1'b0;
            tick(7);
            check($sformatf("vec%0d_q", i), bus.q, vecs[i].exp_q);
            check($sformatf("vec%0d_dir", i), bus.dir, vecs[i].exp_dir);
            check($sformatf("vec%0d_max", i), bus.max_tick, vecs[i].exp_max);
            check($sformatf("vec%0d_min", i), bus.min_tick, vecs[i].exp_min);
        end
        cur_idx = 0;

        // syn_clr in the decode cycle of a forward step.
        bus.load = 1'b1;
        bus.d    = 16'd5;
        tick(1);
        bus.load = 1'b0;
        check("clr_pre_q", bus.q, 5);
        set_idx(1);
        tick(LAT - 1);
        bus.syn_clr = 1'b1;
        tick(1);
        check("clr_q", bus.q, 0);
        check("clr_step_tick", bus.step_tick, 1);
        check("clr_dir", bus.dir, 1);
        bus.syn_clr = 1'b0;
        base_errs = err_pulses;
        tick(6);
        check("clr_no_err", err_pulses - base_errs, 0);
        check("clr_q_after", bus.q, 0);

        // load in the decode cycle of a reverse step.
        set_idx(0);
        tick(LAT - 1);
        bus.load = 1'b1;
        bus.d    = 16'h0040;
        tick(1);
        check("ld_q", bus.q, 16'h0040);
        check("ld_step_tick", bus.step_tick, 1);
        check("ld_dir", bus.dir, 0);
        bus.load = 1'b0;
        tick(6);
        check("ld_q_after", bus.q, 16'h0040);

`ifdef QDEC_INDEX_EN
        // Index pulse during a reverse step clears q; the step is dropped.
        bus.load = 1'b1;
        bus.d    = 16'd100;
        tick(1);
        bus.load = 1'b0;
        set_idx(3);
        bus.z = 1'b1;
        tick(1);
        bus.z = 1'b0;
        tick(LAT - 2);
        check("idx_q_early", bus.q, 100);
        tick(1);
        check("idx_q", bus.q, 0);
        check("idx_step_tick", bus.step_tick, 1);
        check("idx_dir", bus.dir, 0);
        tick(6);
        set_idx(0);
        tick(LAT + 2);
        check("idx_fwd_q", bus.q, 1);
        check("idx_fwd_dir", bus.dir, 1);
`endif

        // Randomized run against a Gray-index model.
        do_reset(0);
        cur_idx    = 0;
        m_q        = '0;
        m_dir      = 1'b0;
        m_err      = 0;
        m_steps    = 0;
        base_steps = step_pulses;
        for (int i = 0; i < 200; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r <= 7) begin
                int delta;
                delta   = (r <= 3) ? 1 : (r <= 6) ? 3 : 2;
                cur_idx = (cur_idx + delta) % 4;
                set_idx(cur_idx);
                tick($urandom_range(LAT + 1, LAT + 4));
                if (delta == 1) begin
                    m_q   = m_q + 1'b1;
                    m_dir = 1'b1;
                    m_steps++;
                end else if (delta == 3) begin
                    m_q   = m_q - 1'b1;
                    m_dir = 1'b0;
                    m_steps++;
                end else if (m_err < 255) begin
                    m_err++;
                end
            end else begin
                logic [31:0] dv;
                dv = $urandom;
                if (r == 8) begin
                    bus.load = 1'b1;
                    bus.d    = dv[N-1:0];
                    m_q      = dv[N-1:0];
                end else begin
                    bus.syn_clr = 1'b1;
                    m_q         = '0;
                end
                tick(1);
                bus.load    = 1'b0;
                bus.syn_clr = 1'b0;
                tick(1);
            end
            check($sformatf("rand%0d_q", i), bus.q, m_q);
            check($sformatf("rand%0d_dir", i), bus.dir, m_dir);
            check($sformatf("rand%0d_errcnt", i), bus.err_cnt, m_err);
        end
        check("rand_pulses", step_pulses - base_steps, m_steps);

        // 300 illegal 00<->11 jumps: q holds, err_cnt saturates, every error pulses.
        do_reset(0);
        cur_idx   = 0;
        base_errs = err_pulses;
        for (int i = 0; i < 300; i++) begin
            cur_idx = (cur_idx + 2) % 4;
            set_idx(cur_idx);
            tick(LAT + 1);
            if (i == 9)   check("sat_errcnt_10", bus.err_cnt, 10);
            if (i == 254) check("sat_errcnt_255", bus.err_cnt, 255);
        end
        tick(4);
        check("sat_pulses", err_pulses - base_errs, 300);
        check("sat_errcnt", bus.err_cnt, 255);
        check("sat_q", bus.q, 0);
        bus.syn_clr = 1'b1;
        tick(1);
        bus.syn_clr = 1'b0;
        bus.load    = 1'b1;
        bus.d       = 16'h00AA;
        tick(1);
        bus.load    = 1'b0;
        check("sat_errcnt_kept", bus.err_cnt, 255);
        check("sat_ld_q", bus.q, 16'h00AA);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/quad_decoder_counter.md
Name: quad_decoder_counter

Overview:
- Quadrature decoder with integrated up/down position counter.
- Turns the two phase inputs (a, b) of an incremental encoder into count-enable and direction, then accumulates them into an N-bit position.
- Same load/clear/tick interface style as the universal binary counter, so software and MMIO wrappers treat both alike.
- Sits between the encoder pins and an MMIO register slot.

Parameters:
- N, 16, position counter width in bits.
- SYNC_STAGES, 2, synchronizer depth on asynchronous inputs (legal values 2..4).

Ports:
- clk  input  1  system clock, all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- a  input  1  encoder phase A, asynchronous to clk.
- b  input  1  encoder phase B, asynchronous to clk.
- syn_clr  input  1  synchronous clear of position.
- load  input  1  load position from d.
- d  input  N  load value.
- q  output  N  current position.
- dir  output  1  direction of last valid step: 1 = up, 0 = down.
- step_tick  output  1  one-cycle pulse on each valid step.
- err_tick  output  1  one-cycle pulse on an illegal transition.
- err_cnt  output  8  saturating count of illegal transitions.
- max_tick  output  1  high when q == 2**N-1.
- min_tick  output  1  high when q == 0.

Behaviour:
- Reset (synchronous, active-high, highest priority):
  - All synchronizer flops, prev-state register, q, dir, err_cnt and arm counter clear to 0.
  - step_tick and err_tick are 0.
  - min_tick = 1, max_tick = 0.
- Synchronizer: a and b each pass through SYNC_STAGES flops, giving the sampled state s = {a_s, b_s}.
- Prev-state register p loads s every cycle.
- Arming:
  - Arm counter runs for SYNC_STAGES+1 cycles after reset release.
  - While unarmed, p tracks s but no step or error is evaluated, so no spurious error occurs when the pins are not at 00 at reset.
- Transition decode, each armed cycle, comparing p to s:
  - Forward sequence (A leads B) is 00 -> 10 -> 11 -> 01 -> 00. Each forward step: q <= q+1, dir <= 1, step_tick = 1.
  - Reverse sequence: q <= q-1, dir <= 0, step_tick = 1.
  - s == p: no change.
  - Both bits changed (00<->11, 10<->01): err_tick = 1. q and dir are unchanged. err_cnt increments, saturating at 255.
- Latency: a pin edge changes q exactly SYNC_STAGES+1 clk cycles later, with step_tick asserted in the same cycle q updates (registered).
- Arithmetic: q is modulo 2**N. 2**N-1 +1 -> 0, and 0 -1 -> 2**N-1. No wrap flag beyond max_tick/min_tick.
- max_tick and min_tick are combinational from q.
- Priority on q: reset > syn_clr > load > (index clear, if enabled) > step.
- When syn_clr or load coincides with a valid step:
  - The step is dropped for q.
  - step_tick and dir still reflect the decoded step.
  - p still updates, so no error follows.
- syn_clr and load do not affect err_cnt. err_cnt is cleared only by reset.
- The decoder assumes input edges are at least SYNC_STAGES+1 cycles apart. Faster input is reported as err_tick and is not miscounted.

Optional Feature:
- Macro: QDEC_INDEX_EN.
- Defined:
  - Adds port z (input, 1, encoder index pulse, asynchronous), synchronized with SYNC_STAGES flops.
  - A rising edge of synchronized z clears q to 0 on the cycle it is detected, SYNC_STAGES+1 cycles after the pin edge.
  - Index clear priority is below load and above step. A coincident step is dropped.
  - Index detection is also gated by arming.
- Undefined: no z port. q is modified only by reset, syn_clr, load and steps.

Test Plan:
- Reset with a=1, b=1 held, release, wait 10 cycles -> q=0, err_cnt=0, err_tick never asserted, min_tick=1.
- Drive 8 forward steps (00,10,11,01,...), 8 cycles apart -> q=8, dir=1, exactly 8 step_tick pulses, each SYNC_STAGES+1 cycles after its pin edge.
- load with d=0xFFFE, then 3 forward steps -> q sequence 0xFFFF (max_tick=1), 0x0000 (min_tick=1), 0x0001. Then 2 reverse steps -> q=0xFFFF, dir=0.
- Jump a,b from 00 to 11 repeatedly 300 times -> q unchanged, 300 err_tick pulses, err_cnt saturates at 255.
- Assert syn_clr in the same cycle a forward step decodes, with q=5 -> q=0 next cycle, step_tick=1, no err_tick on the following cycles.
- With QDEC_INDEX_EN, q=100: pulse z high during a reverse step -> q=0 after SYNC_STAGES+1 cycles. The next forward step gives q=1.
